// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control path: opcodes, ALU ops,
// writeback selects, sequencer states and decode classes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'hA;
  localparam logic [3:0] OP_LDI    = 4'hB;
  localparam logic [3:0] OP_LD     = 4'hC;
  localparam logic [3:0] OP_ST     = 4'hD;
  localparam logic [3:0] OP_BEQ    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;
  localparam logic [3:0] ALU_SLT = 4'h9;
  localparam logic [3:0] ALU_EQ  = 4'hA;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LDI, CLS_LD, CLS_ST, CLS_BEQ, CLS_HALT
  } op_class_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the sequencer and instruction memory, register file,
// ALU and data memory. master = control_unit, slave = the datapath side.
interface control_unit_if #(
  parameter int PC_W  = 8,
  parameter int IMM_W = 16
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [15:0]      imem_data;
  logic [3:0]       rs1_addr;
  logic [3:0]       rs2_addr;
  logic [3:0]       rd_addr;
  logic [3:0]       alu_op;
  logic             alu_zero;
  logic [1:0]       wb_sel;
  logic [IMM_W-1:0] imm;
  logic             reg_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             halted;

  modport master (
    output imem_req, imem_addr, rs1_addr, rs2_addr, rd_addr, alu_op,
           wb_sel, imm, reg_we, dmem_req, dmem_we, halted,
    input  imem_ack, imem_data, alu_zero, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, rs1_addr, rs2_addr, rd_addr, alu_op,
           wb_sel, imm, reg_we, dmem_req, dmem_we, halted,
    output imem_ack, imem_data, alu_zero, dmem_ack
  );
endinterface

// File: rtl/instr_decoder.sv
// Pure field extraction and sequencing class for a latched instruction word.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic [15:0]      instr,
  output logic [3:0]       opcode,
  output logic [3:0]       rd,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [IMM_W-1:0] imm,
  output logic [1:0]       wb_sel,
  output op_class_t        op_class
);

  assign opcode = instr[15:12];
  assign rd     = instr[11:8];
  assign rs1    = instr[7:4];
  assign rs2    = instr[3:0];
  assign imm    = {{(IMM_W-8){1'b0}}, instr[7:0]};

  always_comb begin
    op_class = CLS_NOP;
    wb_sel   = WB_ALU;
    if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
      op_class = CLS_ALU;
    end else begin
      case (opcode)
        OP_LDI:  begin op_class = CLS_LDI; wb_sel = WB_IMM; end
        OP_LD:   begin op_class = CLS_LD;  wb_sel = WB_MEM; end
        OP_ST:   op_class = CLS_ST;
        OP_BEQ:  op_class = CLS_BEQ;
        OP_HALT: op_class = CLS_HALT;
        default: op_class = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer; owns pc and the FSM, all outputs registered.
//   state  | meaning
//   IDLE   | first cycle after reset
//   FETCH  | imem_req high, waiting for imem_ack
//   DECODE | instruction latched, fields registered on exit
//   EXEC   | ALU op or BEQ compare on the ALU
//   MEM    | dmem_req high, waiting for dmem_ack
//   WB     | one-cycle reg_we strobe
//   HALT   | stopped until reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 16
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master bus
);

  state_t           state, nxt;
  logic [PC_W-1:0]  pc;
  logic [15:0]      instr;

  logic [3:0]       d_opcode, d_rd, d_rs1, d_rs2;
  logic [IMM_W-1:0] d_imm;
  logic [1:0]       d_wb_sel;
  op_class_t        d_class;
  logic [PC_W-1:0]  br_off;

  logic             imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, halted_q;
  logic             imem_req_d, dmem_req_d, dmem_we_d, reg_we_d, halted_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [3:0]       rs1_q, rs2_q, rd_q;
  logic [IMM_W-1:0] imm_q;
  logic [1:0]       wb_sel_q;

  instr_decoder #(.IMM_W(IMM_W)) u_dec (
    .instr    (instr),
    .opcode   (d_opcode),
    .rd       (d_rd),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .imm      (d_imm),
    .wb_sel   (d_wb_sel),
    .op_class (d_class)
  );

  // Branch offset is relative to the already-incremented pc.
  assign br_off = {{(PC_W-4){d_rd[3]}}, d_rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      instr      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      halted_q   <= 1'b0;
      alu_op_q   <= ALU_NOP;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      wb_sel_q   <= WB_ALU;
    end else begin
      state      <= nxt;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      reg_we_q   <= reg_we_d;
      halted_q   <= halted_d;
      alu_op_q   <= alu_op_d;
      if (state == S_FETCH && bus.imem_ack) begin
        instr <= bus.imem_data;
        pc    <= pc + PC_W'(1);
      end else if (state == S_EXEC && d_class == CLS_BEQ && bus.alu_zero) begin
        pc <= pc + br_off;
      end
      if (state == S_DECODE) begin
        rs1_q    <= d_rs1;
        rs2_q    <= d_rs2;
        rd_q     <= d_rd;
        imm_q    <= d_imm;
        wb_sel_q <= d_wb_sel;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) nxt = S_DECODE;
      S_DECODE: begin
        case (d_class)
          CLS_NOP:         nxt = S_FETCH;
          CLS_HALT:        nxt = S_HALT;
          CLS_LD, CLS_ST:  nxt = S_MEM;
          CLS_LDI:         nxt = S_WB;
          default:         nxt = S_EXEC;
        endcase
      end
      S_EXEC:   nxt = (d_class == CLS_BEQ) ? S_FETCH : S_WB;
      S_MEM:    if (bus.dmem_ack) nxt = (d_class == CLS_ST) ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it once registered.
  always_comb begin
    imem_req_d = (nxt == S_FETCH);
    dmem_req_d = (nxt == S_MEM);
    dmem_we_d  = (nxt == S_MEM) && (d_class == CLS_ST);
    reg_we_d   = (nxt == S_WB);
    halted_d   = (nxt == S_HALT);
    alu_op_d   = ALU_NOP;
    if (nxt == S_EXEC)
      alu_op_d = (d_class == CLS_BEQ) ? ALU_SUB : d_opcode;
    else if (nxt == S_WB && state == S_EXEC)
      alu_op_d = alu_op_q;
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc;
  assign bus.rs1_addr  = rs1_q;
  assign bus.rs2_addr  = rs2_q;
  assign bus.rd_addr   = rd_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.imm       = imm_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: memory responders feed instructions and push ISA-level
// expectations; an independent monitor pops and compares on DUT events.
module tb_control_unit;

  logic clk, rst;

  control_unit_if #(.PC_W(8), .IMM_W(16)) bus ();
  control_unit #(.PC_W(8), .IMM_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [7:0] addr; int gap; } fetch_exp_t;
  typedef struct { logic [3:0] rd; logic [1:0] wb; logic [3:0] alu; logic [15:0] imm; } wb_exp_t;
  typedef struct { logic we; logic [3:0] rs1; logic [3:0] rs2; int hold; } dm_exp_t;
  typedef struct { logic [15:0] instr; logic zero; int di; int dd; } stim_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  fetch_exp_t fetch_q[$];
  wb_exp_t    wb_q[$];
  dm_exp_t    dm_q[$];
  logic [3:0] alu_q[$];
  stim_t      stim_q[$];

  logic [7:0] model_pc;
  int         cur_dd;
  logic       fetch_active;
  int         icnt;
  stim_t      cur_s;
  logic       dm_active;
  int         dcnt;

  logic       p_ireq, p_dreq, p_we;
  logic [3:0] p_alu;
  int         last_rise, dhold, dexp;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ISA-level reference: next pc, writeback/memory/ALU expectations and the cycle budget.
  task automatic apply_model(stim_t s);
    logic [3:0] op;
    logic [7:0] npc;
    int base, dd;
    wb_exp_t w;
    dm_exp_t m;
    fetch_exp_t f;
    op = s.instr[15:12];
    npc = model_pc + 8'd1;
    dd = 0;
    base = 2;
    w.rd = s.instr[11:8];
    w.imm = {8'h00, s.instr[7:0]};
    w.alu = 4'h0;
    w.wb = 2'b00;
    if (op >= 4'h1 && op <= 4'hA) begin
      base = 4; w.alu = op; alu_q.push_back(op); wb_q.push_back(w);
    end else if (op == 4'hB) begin
      base = 3; w.wb = 2'b01; wb_q.push_back(w);
    end else if (op == 4'hC || op == 4'hD) begin
      dd = s.dd;
      m.we = (op == 4'hD); m.rs1 = s.instr[7:4]; m.rs2 = s.instr[3:0]; m.hold = dd + 1;
      dm_q.push_back(m);
      if (op == 4'hC) begin base = 4; w.wb = 2'b10; wb_q.push_back(w); end
      else base = 3;
    end else if (op == 4'hE) begin
      base = 3; alu_q.push_back(4'h2);
      if (s.zero) npc = npc + {{4{s.instr[11]}}, s.instr[11:8]};
    end
    if (op != 4'hF) begin
      f.addr = npc; f.gap = base + s.di + dd;
      fetch_q.push_back(f);
    end
    model_pc = npc;
    cur_dd = dd;
  endtask

  task automatic add(logic [15:0] instr, logic zero, int di, int dd);
    stim_t s;
    s.instr = instr; s.zero = zero; s.di = di; s.dd = dd;
    stim_q.push_back(s);
  endtask

  task automatic add_random(int n);
    for (int i = 0; i < n; i++)
      add({4'($urandom_range(0, 14)), 12'($urandom)}, 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  task automatic restart_model();
    fetch_exp_t f;
    fetch_q.delete(); wb_q.delete(); dm_q.delete(); alu_q.delete(); stim_q.delete();
    model_pc = 8'h00;
    f.addr = 8'h00; f.gap = -1;
    fetch_q.push_back(f);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_imem_req"}, 32'(bus.imem_req), 0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
    check({tag, "_dmem_req"}, 32'(bus.dmem_req), 0);
    check({tag, "_dmem_we"}, 32'(bus.dmem_we), 0);
    check({tag, "_reg_we"}, 32'(bus.reg_we), 0);
    check({tag, "_halted"}, 32'(bus.halted), 0);
    check({tag, "_alu_op"}, 32'(bus.alu_op), 0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((stim_q.size() > 0 || fetch_active) && n < budget) begin
      @(negedge clk); n++;
    end
    check("drain_in_time", 32'(n < budget), 1);
    repeat (12) @(negedge clk);
  endtask

  task automatic check_retired(string tag);
    check({tag, "_wb_left"}, 32'(wb_q.size()), 0);
    check({tag, "_dmem_left"}, 32'(dm_q.size()), 0);
    check({tag, "_alu_left"}, 32'(alu_q.size()), 0);
  endtask

  // Instruction memory responder (also drives alu_zero for the instruction it returns).
  initial begin
    bus.imem_ack = 0; bus.imem_data = 0; bus.alu_zero = 0; fetch_active = 0; icnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fetch_active = 0;
        bus.imem_ack = 1'($urandom_range(0, 1));
        bus.imem_data = 16'($urandom);
      end else if (bus.imem_req) begin
        if (!fetch_active) begin
          fetch_active = 1;
          if (stim_q.size() > 0) cur_s = stim_q.pop_front();
          else begin cur_s.instr = 16'h0000; cur_s.zero = 0; cur_s.di = 0; cur_s.dd = 0; end
          icnt = cur_s.di;
        end
        if (icnt == 0) begin
          bus.imem_ack = 1; bus.imem_data = cur_s.instr; bus.alu_zero = cur_s.zero;
          apply_model(cur_s);
          fetch_active = 0;
        end else begin
          icnt--; bus.imem_ack = 0; bus.imem_data = 16'($urandom);
        end
      end else begin
        bus.imem_ack = ($urandom_range(0, 3) == 0);
        bus.imem_data = 16'($urandom);
      end
    end
  end

  // Data memory responder.
  initial begin
    bus.dmem_ack = 0; dm_active = 0; dcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dm_active = 0;
        bus.dmem_ack = 1'($urandom_range(0, 1));
      end else if (bus.dmem_req) begin
        if (!dm_active) begin dm_active = 1; dcnt = cur_dd; end
        if (dcnt == 0) begin bus.dmem_ack = 1; dm_active = 0; end
        else begin dcnt--; bus.dmem_ack = 0; end
      end else begin
        bus.dmem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: compares every observable event against the queued expectations.
  initial begin
    fetch_exp_t f;
    wb_exp_t w;
    dm_exp_t m;
    logic [3:0] a;
    p_ireq = 0; p_dreq = 0; p_we = 0; p_alu = 0; last_rise = 0; dhold = 0; dexp = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p_ireq = 0; p_dreq = 0; p_we = 0; p_alu = 0; dhold = 0;
      end else begin
        if (bus.imem_req && !p_ireq) begin
          if (fetch_q.size() == 0) check("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFF_FFFF);
          else begin
            f = fetch_q.pop_front();
            check("fetch_addr", 32'(bus.imem_addr), 32'(f.addr));
            if (f.gap >= 0) check("fetch_gap_cycles", 32'(cyc - last_rise), 32'(f.gap));
          end
          last_rise = cyc;
        end
        if (bus.alu_op != 4'h0 && p_alu == 4'h0) begin
          if (alu_q.size() == 0) check("unexpected_alu_op", 32'(bus.alu_op), 0);
          else begin a = alu_q.pop_front(); check("alu_op", 32'(bus.alu_op), 32'(a)); end
        end
        if (bus.reg_we) begin
          check("reg_we_single_cycle", 32'(p_we), 0);
          if (!p_we) begin
            if (wb_q.size() == 0) check("unexpected_reg_we", 32'(bus.rd_addr), 32'hFFFF_FFFF);
            else begin
              w = wb_q.pop_front();
              check("wb_rd_addr", 32'(bus.rd_addr), 32'(w.rd));
              check("wb_sel", 32'(bus.wb_sel), 32'(w.wb));
              check("wb_alu_op", 32'(bus.alu_op), 32'(w.alu));
              check("wb_imm", 32'(bus.imm), 32'(w.imm));
            end
          end
        end
        if (bus.dmem_req && !p_dreq) begin
          if (dm_q.size() == 0) check("unexpected_dmem_req", 32'(bus.dmem_we), 32'hFFFF_FFFF);
          else begin
            m = dm_q.pop_front();
            check("dmem_we", 32'(bus.dmem_we), 32'(m.we));
            check("dmem_rs1", 32'(bus.rs1_addr), 32'(m.rs1));
            check("dmem_rs2", 32'(bus.rs2_addr), 32'(m.rs2));
            check("dmem_alu_op_idle", 32'(bus.alu_op), 0);
            dexp = m.hold;
          end
          dhold = 0;
        end
        if (bus.dmem_req) dhold++;
        if (!bus.dmem_req && p_dreq) check("dmem_req_hold", 32'(dhold), 32'(dexp));
        p_ireq = bus.imem_req; p_dreq = bus.dmem_req; p_we = bus.reg_we; p_alu = bus.alu_op;
      end
    end
  end

  initial begin
    int n, busy;
    rst = 1;
    model_pc = 0;
    cur_dd = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    restart_model();
    add(16'hEF00, 1, 0, 0);   // BEQ -1 taken at pc 0: stays at 0
    add(16'hEE00, 1, 0, 0);   // BEQ -2 taken: 1 - 2 wraps to FF
    add(16'h0000, 0, 0, 0);   // NOP at FF: pc wraps to 00
    add(16'h1321, 0, 0, 0);   // ADD r3 = r2 + r1
    for (int i = 0; i < 4; i++) add(16'h0000, 0, 0, 0);
    add(16'hE312, 1, 0, 0);   // pc 5, taken -> 9
    add(16'hE312, 0, 0, 0);   // pc 9, not taken -> A
    add(16'hC240, 0, 0, 2);   // LD with dmem_req held 3 cycles
    add(16'hD050, 0, 0, 0);   // ST
    add(16'hB7A5, 0, 0, 0);   // LDI r7 = 00A5
    @(negedge clk);
    #1 rst = 0;
    check("req_low_before_first_edge", 32'(bus.imem_req), 0);
    @(negedge clk);
    check("req_one_cycle_after_reset", 32'(bus.imem_req), 1);
    drain(2000);
    check_retired("directed");

    add_random(400);
    drain(20000);
    check_retired("random");

    add(16'hF000, 0, 0, 0);
    n = 0;
    while (!bus.halted && n < 100) begin @(negedge clk); n++; end
    check("halted_set", 32'(bus.halted), 1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req || !bus.halted) busy++;
    end
    check("halt_quiet_20_cycles", 32'(busy), 0);
    check_retired("halt");

    #1 rst = 1;
    #1 check_zero("halt_reset");
    restart_model();
    add(16'h1321, 0, 1, 0);
    add(16'hC240, 0, 0, 20);
    @(negedge clk);
    #1 rst = 0;
    n = 0;
    while (!bus.dmem_req && n < 200) begin @(negedge clk); n++; end
    check("mid_mem_reached", 32'(bus.dmem_req), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 check_zero("mid_mem_reset");
    restart_model();
    add(16'hB7A5, 0, 0, 0);
    add_random(40);
    @(negedge clk);
    #1 rst = 0;
    drain(5000);
    check_retired("after_mid_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer that fetches 16-bit instructions, decodes them and drives the ALU's alu_op and operand selects. It consumes the ALU zero flag for branches and sequences register writeback and data-memory access.
- It is the initiating side of the ALU interface and sits between instruction memory, data memory and the register file of the 16-bit CPU.

Parameters:
- PC_W, 8, program counter / instruction address width
- IMM_W, 16, width of the immediate driven to the writeback mux

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete, imem_data valid this cycle
- imem_data  in  16  instruction word
- rs1_addr  out  4  register-file read port A (ALU a)
- rs2_addr  out  4  register-file read port B (ALU b)
- rd_addr  out  4  register-file write address
- alu_op  out  4  ALU operation code
- alu_zero  in  1  ALU zero flag
- wb_sel  out  2  writeback source: 00 ALU result, 01 imm, 10 dmem read data
- imm  out  IMM_W  zero-extended instr[7:0]
- reg_we  out  1  register write strobe, one cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data memory complete
- halted  out  1  core stopped

Behaviour:
- Instruction format: [15:12] opcode, [11:8] rd or branch offset, [7:4] rs1, [3:0] rs2. LDI uses [7:0] as the immediate.
- Opcodes:
  - 0000 NOP
  - 0001-1010 ALU ops; alu_op = opcode, rd <= result
  - 1011 LDI: rd <= imm
  - 1100 LD: rd <= mem[rs1]
  - 1101 ST: mem[rs1] <= rs2
  - 1110 BEQ: if rs1 == rs2, pc <= pc + sext(instr[11:8])
  - 1111 HALT
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are registered.
- Reset (async, immediate):
  - state = IDLE, pc = 0.
  - All outputs 0, including imem_req, dmem_req, reg_we, halted and alu_op = 0000.
  - Pending memory requests are abandoned.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - Hold until imem_ack; on ack latch imem_data, pc <= pc + 1 (wraps mod 2^PC_W), imem_req drops next cycle, go to DECODE.
- DECODE: drive rs1/rs2/rd/imm/wb_sel from the latched instruction, then:
  - NOP -> FETCH
  - HALT -> HALT
  - ST/LD -> MEM
  - LDI -> WB
  - ALU ops and BEQ -> EXEC
- EXEC:
  - ALU ops: alu_op = opcode, held through WB; -> WB.
  - BEQ: alu_op = 0010 (SUB). If alu_zero, pc <= pc + sext(offset) with offset relative to the already-incremented pc, wrapping mod 2^PC_W. Then -> FETCH.
- MEM:
  - dmem_req = 1, dmem_we = (opcode == ST); hold until dmem_ack.
  - ST -> FETCH; LD -> WB (wb_sel = 10).
- WB: reg_we = 1 for exactly one cycle -> FETCH.
- Outside EXEC/WB, alu_op = 0000.
- Latency with same-cycle acks (cycles from FETCH entry to next FETCH entry):
  - NOP 2
  - BEQ 3
  - ST 3
  - LDI 3
  - ALU op 4
  - LD 4
- HALT: sticky, halted = 1, no requests issued; left only via rst.
- imem_ack/dmem_ack while the corresponding req is low: ignored.
- Acks asserted during rst: ignored.
- BEQ with offset 0 is a no-op branch. Offset -1 loops on the BEQ.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_HALT)
  - ALU op constants (ALU_ADD = 4'b0001 .. ALU_EQ = 4'b1010)
  - wb_sel encodings (WB_ALU, WB_IMM, WB_MEM)
  - state enum
- Sub-module instr_decoder: combinational field extraction plus a next-state class (nop/alu/ldi/ld/st/beq/halt) from the latched instruction. control_unit keeps the FSM and pc.

Test Plan:
- Reset release, imem_ack tied high, imem_data = 16'h1321 (ADD r3 = r2 + r1) -> imem_req rises 1 cycle after reset. Then alu_op = 0001, rd_addr = 3, rs1 = 2, rs2 = 1. reg_we pulses once with wb_sel = 00, 4 cycles per instruction, pc = 1.
- BEQ 16'hE312 at pc = 5 with alu_zero = 1 -> next imem_addr = 6 + 3 = 9. Same with alu_zero = 0 -> next imem_addr = 6. BEQ offset 4'hF at pc = 0 -> imem_addr stays 0.
- LD 16'hC240 with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles with dmem_we = 0, then reg_we with wb_sel = 10, rd = 2. ST 16'hD050 -> dmem_we = 1, reg_we never asserted.
- pc = 8'hFF fetching NOP -> pc wraps to 8'h00. LDI 16'hB7A5 -> imm = 16'h00A5, rd = 7, wb_sel = 01.
- HALT 16'hF000 -> halted = 1, imem_req stays 0 for 20 cycles. Then rst pulse -> halted = 0, pc = 0.
- rst asserted mid-MEM with dmem_req = 1 -> dmem_req and all outputs 0 immediately (asynchronously). Fetch restarts at pc = 0.
